// File: rtl/bfp_pkg.sv
// rtl/bfp_pkg.sv - shared widths, state encoding and sizing helpers for bfp_group_align
package bfp_pkg;

    localparam int EXP_WIDTH_DEF      = 4;
    localparam int MANTISSA_WIDTH_DEF = 3;
    localparam int SIGN_WIDTH_DEF     = 1;
    localparam int GUARD_WIDTH_DEF    = 2;
    localparam int GROUP_BEATS_DEF    = 4;

    localparam int MAG_W = 1 + MANTISSA_WIDTH_DEF + GUARD_WIDTH_DEF;
    localparam int AW    = SIGN_WIDTH_DEF + MAG_W;
    localparam int CNT_W = $clog2(GROUP_BEATS_DEF + 1);

    typedef enum logic {
        FILL  = 1'b0,
        DRAIN = 1'b1
    } bfp_state_t;

    function automatic int mag_width(input int man_w, input int guard_w);
        return 1 + man_w + guard_w;
    endfunction

    function automatic int cnt_width(input int beats);
        return $clog2(beats + 1);
    endfunction

endpackage

// File: rtl/bfp_lane_align.sv
// rtl/bfp_lane_align.sv - one lane: align a packed minifloat to the group exponent
// with truncation or round-nearest-even on the bits shifted out.
module bfp_lane_align
    import bfp_pkg::*;
#(
    parameter int EXP_WIDTH      = EXP_WIDTH_DEF,
    parameter int MANTISSA_WIDTH = MANTISSA_WIDTH_DEF,
    parameter int SIGN_WIDTH     = SIGN_WIDTH_DEF,
    parameter int GUARD_WIDTH    = GUARD_WIDTH_DEF
) (
    input  logic [SIGN_WIDTH+EXP_WIDTH+MANTISSA_WIDTH-1:0] i_elem,
    input  logic [EXP_WIDTH-1:0]                           i_exp_max,
    input  logic                                           i_rnd_mode,
    output logic [SIGN_WIDTH+MANTISSA_WIDTH+GUARD_WIDTH:0] o_lane
);

    localparam int LMAG_W = mag_width(MANTISSA_WIDTH, GUARD_WIDTH);
    // Fraction field is wider than any possible shift, so every dropped bit is kept for rounding.
    localparam int FRAC_W = 1 << EXP_WIDTH;
    localparam logic [FRAC_W-1:0] HALF = FRAC_W'(1) << (FRAC_W - 1);

    logic [SIGN_WIDTH-1:0]      w_sign;
    logic [EXP_WIDTH-1:0]       w_exp;
    logic [MANTISSA_WIDTH-1:0]  w_man;
    logic [EXP_WIDTH-1:0]       w_e_eff;
    logic [EXP_WIDTH-1:0]       w_shift;
    logic [LMAG_W-1:0]          w_mag0;
    logic [LMAG_W+FRAC_W-1:0]   w_ext;
    logic [LMAG_W-1:0]          w_mag;
    logic [FRAC_W-1:0]          w_frac;
    logic                       w_round_up;

    assign {w_sign, w_exp, w_man} = i_elem;
    assign w_e_eff = (w_exp == '0) ? EXP_WIDTH'(1) : w_exp;
    assign w_shift = i_exp_max - w_e_eff;
    assign w_mag0  = {(w_exp != '0), w_man, {GUARD_WIDTH{1'b0}}};
    assign w_ext   = {w_mag0, {FRAC_W{1'b0}}} >> w_shift;
    assign w_mag   = w_ext[LMAG_W+FRAC_W-1:FRAC_W];
    assign w_frac  = w_ext[FRAC_W-1:0];

    assign w_round_up = i_rnd_mode && ((w_frac > HALF) || ((w_frac == HALF) && w_mag[0]));
    assign o_lane     = {w_sign, w_mag + LMAG_W'(w_round_up)};

endmodule

// File: rtl/bfp_group_align.sv
// rtl/bfp_group_align.sv - buffers a group of minifloat beats, finds the shared max exponent,
// then drains each beat as sign + aligned magnitude.
module bfp_group_align
    import bfp_pkg::*;
#(
    parameter int EXP_WIDTH      = EXP_WIDTH_DEF,
    parameter int MANTISSA_WIDTH = MANTISSA_WIDTH_DEF,
    parameter int SIGN_WIDTH     = SIGN_WIDTH_DEF,
    parameter int FP_WIDTH       = SIGN_WIDTH + EXP_WIDTH + MANTISSA_WIDTH,
    parameter int LANES          = 128,
    parameter int GROUP_BEATS    = GROUP_BEATS_DEF,
    parameter int GUARD_WIDTH    = GUARD_WIDTH_DEF
) (
    input  logic                                                       clk,
    input  logic                                                       rst,
    input  logic                                                       rnd_mode,
    input  logic [LANES*FP_WIDTH-1:0]                                  data_in,
    input  logic                                                       data_in_vld,
    input  logic                                                       data_in_last,
    output logic                                                       data_in_rdy,
    output logic [EXP_WIDTH-1:0]                                       exp_max,
    output logic [LANES*(SIGN_WIDTH+1+MANTISSA_WIDTH+GUARD_WIDTH)-1:0] aligned,
    output logic                                                       aligned_vld,
    output logic                                                       aligned_last,
    input  logic                                                       aligned_rdy
);

    localparam int LANE_AW  = SIGN_WIDTH + mag_width(MANTISSA_WIDTH, GUARD_WIDTH);
    localparam int CNT_BITS = cnt_width(GROUP_BEATS);
    localparam int IDX_BITS = (GROUP_BEATS > 1) ? $clog2(GROUP_BEATS) : 1;

    bfp_state_t                r_state;
    bfp_state_t                w_next_state;
    logic [CNT_BITS-1:0]       r_wr_cnt;
    logic [CNT_BITS-1:0]       r_rd_cnt;
    logic [CNT_BITS-1:0]       r_n_beats;
    logic [EXP_WIDTH-1:0]      r_exp_max;
    logic [LANES*FP_WIDTH-1:0] r_buf [GROUP_BEATS];

    logic                      w_accept;
    logic                      w_close;
    logic                      w_out_hs;
    logic [EXP_WIDTH-1:0]      w_beat_max;
    logic [EXP_WIDTH-1:0]      w_run_max;
    logic [LANES*FP_WIDTH-1:0] w_rd_beat;
    logic [LANES*LANE_AW-1:0]  w_aligned;

    assign w_accept = data_in_vld && data_in_rdy;
    assign w_close  = (r_wr_cnt == CNT_BITS'(GROUP_BEATS - 1)) || data_in_last;
    assign w_out_hs = aligned_vld && aligned_rdy;

    // Subnormals count as exponent 1, so the reduction starts from 1 rather than 0.
    always_comb begin
        w_beat_max = EXP_WIDTH'(1);
        for (int i = 0; i < LANES; i++) begin
            if (data_in[i*FP_WIDTH+MANTISSA_WIDTH +: EXP_WIDTH] > w_beat_max) begin
                w_beat_max = data_in[i*FP_WIDTH+MANTISSA_WIDTH +: EXP_WIDTH];
            end
        end
    end

    assign w_run_max = ((r_wr_cnt == '0) || (w_beat_max > r_exp_max)) ? w_beat_max : r_exp_max;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state <= FILL;
        end else begin
            r_state <= w_next_state;
        end
    end

    always_comb begin
        w_next_state = r_state;
        data_in_rdy  = 1'b0;
        aligned_vld  = 1'b0;
        aligned_last = 1'b0;
        case (r_state)
            FILL: begin
                data_in_rdy = 1'b1;
                if (data_in_vld && w_close) begin
                    w_next_state = DRAIN;
                end
            end
            DRAIN: begin
                aligned_vld  = 1'b1;
                aligned_last = (r_rd_cnt == r_n_beats - CNT_BITS'(1));
                if (aligned_rdy && aligned_last) begin
                    w_next_state = FILL;
                end
            end
            default: w_next_state = FILL;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_wr_cnt  <= '0;
            r_rd_cnt  <= '0;
            r_n_beats <= '0;
            r_exp_max <= '0;
        end else if (w_accept) begin
            r_wr_cnt  <= r_wr_cnt + CNT_BITS'(1);
            r_exp_max <= w_run_max;
            if (w_close) begin
                r_n_beats <= r_wr_cnt + CNT_BITS'(1);
            end
        end else if (w_out_hs) begin
            if (aligned_last) begin
                r_rd_cnt <= '0;
                r_wr_cnt <= '0;
            end else begin
                r_rd_cnt <= r_rd_cnt + CNT_BITS'(1);
            end
        end
    end

    // Buffer contents need no reset: the write counter alone decides what is valid.
    always_ff @(posedge clk) begin
        if (w_accept) begin
            r_buf[r_wr_cnt[IDX_BITS-1:0]] <= data_in;
        end
    end

    assign w_rd_beat = r_buf[r_rd_cnt[IDX_BITS-1:0]];

    for (genvar g = 0; g < LANES; g++) begin : g_lane
        bfp_lane_align #(
            .EXP_WIDTH      (EXP_WIDTH),
            .MANTISSA_WIDTH (MANTISSA_WIDTH),
            .SIGN_WIDTH     (SIGN_WIDTH),
            .GUARD_WIDTH    (GUARD_WIDTH)
        ) u_lane (
            .i_elem     (w_rd_beat[g*FP_WIDTH +: FP_WIDTH]),
            .i_exp_max  (r_exp_max),
            .i_rnd_mode (rnd_mode),
            .o_lane     (w_aligned[g*LANE_AW +: LANE_AW])
        );
    end

    assign exp_max = r_exp_max;
    assign aligned = aligned_vld ? w_aligned : '0;

endmodule
